seg7_scan_driver: RTL and testbench

//   Multi-digit, time-multiplexed 7-segment display driver. It generalises the

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_scan_driver_decode.sv | 27 ++
 rtl/seg7_scan_driver.sv | 125 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed 7-segment driver.
// Segment vectors are {g,f,e,d,c,b,a} in lit polarity (1 = segment on).
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_BLANK = 7'h00;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_decode.sv
// BCD code to lit-polarity segment pattern; codes 10..15 decode to blank.
// Purely combinational, shared by all digits through the scan mux.
module bcd_seg_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed DIGITS-digit 7-segment driver with per-slot blanking gap.
// Define SEG7_LZ_BLANK_EN to enable leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_CYC      = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an
);

  localparam int CNT_W = clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? clog2(DIGITS) : 1;

  localparam logic              SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic              AN_INV  = (AN_ACTIVE_LOW != 0);
  localparam seg_t              SEG_OFF = {7{SEG_INV}};
  localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{AN_INV}};

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] sh_bcd_q, sh_bcd_d;
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
  seg_t                seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic [3:0]          cur_code;
  seg_t                dec_seg;
  seg_t                seg_lit;
  logic [DIGITS-1:0]   an_lit;

  assign cur_code = sh_bcd_q[4*int'(idx_q) +: 4];

  bcd_seg_decode u_dec (
    .code (cur_code),
    .seg  (dec_seg)
  );

`ifdef SEG7_LZ_BLANK_EN
  logic [DIGITS-1:0] lz_blank;
  logic              lead;

  // Walk from the leftmost digit; digit 0 is never part of the mask.
  always_comb begin
    lead     = 1'b1;
    lz_blank = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      lead        = lead & (sh_bcd_q[4*k +: 4] == 4'd0);
      lz_blank[k] = lead;
    end
  end

  always_comb begin
    seg_lit = dec_seg;
    if (lz_blank[idx_q]) seg_lit = SEG_BLANK;
  end
`else
  always_comb begin
    seg_lit = dec_seg;
  end
`endif

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      if (idx_q == IDX_W'(DIGITS - 1)) idx_d = '0;
      else                             idx_d = idx_q + IDX_W'(1);
    end
  end

  always_comb begin
    sh_bcd_d = sh_bcd_q;
    sh_dp_d  = sh_dp_q;
    if (load) begin
      sh_bcd_d = bcd_in;
      sh_dp_d  = dp_in;
    end
  end

  always_comb begin
    an_lit = '0;
    if (int'(cnt_q) >= BLANK_CYC) an_lit[idx_q] = 1'b1;
    seg_d = seg_lit ^ SEG_OFF;
    dp_d  = sh_dp_q[idx_q] ^ SEG_INV;
    an_d  = an_lit ^ AN_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      sh_bcd_q <= '0;
      sh_dp_q  <= '0;
      seg_q    <= SEG_OFF;
      dp_q     <= SEG_INV;
      an_q     <= AN_OFF;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sh_bcd_q <= sh_bcd_d;
      sh_dp_q  <= sh_dp_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench: active-low and active-high instances share all inputs.
// Tables hold active-low seg values {d3,d2,d1,d0}; the high instance expects their inverse.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        load;
  logic [6:0]  seg_l, seg_h;
  logic        dp_l, dp_h;
  logic [3:0]  an_l, an_h;

  int vec_cnt;
  int err_cnt;
  int n;

  seg7_scan_driver #(
    .DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) u_dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
    .seg(seg_l), .dp(dp_l), .an(an_l)
  );

  seg7_scan_driver #(
    .DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1),
    .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)
  ) u_pol (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
    .seg(seg_h), .dp(dp_h), .an(an_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    if (rst) n = 0;
    else     n = n + 1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s n=%0d obs=%h exp=%h", tag, n, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_an_l"},  {4'b0, an_l},  8'h0F);
    chk({tag, "_seg_l"}, {1'b0, seg_l}, 8'h7F);
    chk({tag, "_dp_l"},  {7'b0, dp_l},  8'h01);
    chk({tag, "_an_h"},  {4'b0, an_h},  8'h00);
    chk({tag, "_seg_h"}, {1'b0, seg_h}, 8'h00);
    chk({tag, "_dp_h"},  {7'b0, dp_h},  8'h00);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    bcd_in = v;
    dp_in  = d;
    load   = 1'b1;
    step();
    load   = 1'b0;
    bcd_in = ~v;
    dp_in  = ~d;
  endtask

  // tbl = {d3,d2,d1,d0} active-low patterns, dpl = digits whose dp is lit.
  task automatic run_frame(input string tag, input logic [27:0] tbl,
                           input logic [3:0] dpl);
    int c;
    int i;
    logic [3:0] ea;
    logic [6:0] es;
    for (int e = 0; e < 16; e++) begin
      step();
      c  = (n - 1) % 4;
      i  = ((n - 1) / 4) % 4;
      ea = (c == 0) ? 4'hF : ~(4'b0001 << i);
      es = tbl[7*i +: 7];
      chk({tag, "_an_l"},  {4'b0, an_l},  {4'b0, ea});
      chk({tag, "_seg_l"}, {1'b0, seg_l}, {1'b0, es});
      chk({tag, "_dp_l"},  {7'b0, dp_l},  {7'b0, ~dpl[i]});
      chk({tag, "_an_h"},  {4'b0, an_h},  {4'b0, ~ea});
      chk({tag, "_seg_h"}, {1'b0, seg_h}, {1'b0, ~es});
      chk({tag, "_dp_h"},  {7'b0, dp_h},  {7'b0, dpl[i]});
    end
  endtask

`ifdef SEG7_LZ_BLANK_EN
  localparam logic [27:0] T_ZERO = {7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [27:0] T_0008 = {7'h7F, 7'h7F, 7'h7F, 7'h00};
  localparam logic [27:0] T_0050 = {7'h7F, 7'h7F, 7'h12, 7'h40};
  localparam logic [6:0]  MID_D1 = 7'h7F;
  localparam logic [6:0]  MID_D2 = 7'h7F;
`else
  localparam logic [27:0] T_ZERO = {7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [27:0] T_0008 = {7'h40, 7'h40, 7'h40, 7'h00};
  localparam logic [27:0] T_0050 = {7'h40, 7'h40, 7'h12, 7'h40};
  localparam logic [6:0]  MID_D1 = 7'h40;
  localparam logic [6:0]  MID_D2 = 7'h40;
`endif
  localparam logic [27:0] T_1234 = {7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [27:0] T_A7F8 = {7'h7F, 7'h78, 7'h7F, 7'h00};

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    n       = 0;
    rst     = 1'b1;
    load    = 1'b1;
    bcd_in  = 16'h1234;
    dp_in   = 4'hF;

    for (int r = 0; r < 3; r++) begin
      step();
      chk_reset("rst_hold");
    end

    rst  = 1'b0;
    load = 1'b0;
    run_frame("post_rst", T_ZERO, 4'b0000);

    do_load(16'h1234, 4'b0010);
    run_frame("ld_1234", T_1234, 4'b0010);

    do_load(16'hA7F8, 4'b0000);
    run_frame("ld_a7f8", T_A7F8, 4'b0000);

    while (n % 16 != 6) step();
    bcd_in = 16'h0000;
    dp_in  = 4'b0000;
    load   = 1'b1;
    step();
    chk("mid_ld_an",   {4'b0, an_l},  8'h0D);
    chk("mid_ld_seg",  {1'b0, seg_l}, 8'h7F);
    load   = 1'b0;
    bcd_in = 16'hFFFF;
    step();
    chk("mid_new_an",  {4'b0, an_l},  8'h0D);
    chk("mid_new_seg", {1'b0, seg_l}, {1'b0, MID_D1});
    step();
    chk("mid_d2_an",   {4'b0, an_l},  8'h0F);
    chk("mid_d2_seg",  {1'b0, seg_l}, {1'b0, MID_D2});
    step();
    chk("mid_d2e_an",  {4'b0, an_l},  8'h0B);

    rst = 1'b1;
    step();
    chk_reset("mid_rst");
    rst = 1'b0;
    run_frame("post_rst2", T_ZERO, 4'b0000);

    do_load(16'h0008, 4'b0000);
    run_frame("ld_0008", T_0008, 4'b0000);

    do_load(16'h0050, 4'b1000);
    run_frame("ld_0050", T_0050, 4'b1000);

    do_load(16'h0000, 4'b0000);
    run_frame("ld_0000", T_ZERO, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
